// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle integer ALU: op codes, FSM states and
// the carry-less product slice selector.
package alu_pkg;

    localparam int XMAX = 64;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLL    = 4'd2,
        OP_SRL    = 4'd3,
        OP_SRA    = 4'd4,
        OP_SLT    = 4'd5,
        OP_SLTU   = 4'd6,
        OP_XOR    = 4'd7,
        OP_OR     = 4'd8,
        OP_AND    = 4'd9,
        OP_CLMUL  = 4'd10,
        OP_CLMULH = 4'd11,
        OP_CLMULR = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_mc_state_t;

    // p holds a 2w-bit product zero-extended to 2*XMAX; caller keeps low w bits
    function automatic logic [XMAX-1:0] clmul_sel(
        input logic [2*XMAX-1:0] p,
        input int                w,
        input logic [3:0]        op
    );
        logic [2*XMAX-1:0] s;
        s = p;
        if (op == OP_CLMULH) s = p >> w;
        else if (op == OP_CLMULR) s = p >> (w - 1);
        return s[XMAX-1:0];
    endfunction

endpackage

// File: rtl/clmul_step.sv
// One iteration of the carry-less multiply: XOR of a shifted by each set
// bit of a STEP-bit slice of b, offset by the slice base.
module clmul_step #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    parameter int BW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [STEP-1:0]    b_slice,
    input  logic [BW-1:0]      base,
    output logic [2*WIDTH-1:0] part
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    always_comb begin
        part = '0;
        for (int j = 0; j < STEP; j++) begin
            if (b_slice[j]) part = part ^ (a_ext << (int'(base) + j));
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked integer ALU: single-cycle simple ops plus
// iterative carry-less multiplies, STEP bits of b per cycle.
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             w64,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAGW-1:0]  tag_out,
    output logic             busy
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam int SW = $clog2(STEP);

    alu_mc_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, part;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         op_q, op_d;
    logic [TAGW-1:0]    tag_q, tag_d;

    logic               accept, is_clmul, last;
    logic [BW-1:0]      base;
    logic [STEP-1:0]    b_slice;
    logic [XMAX-1:0]    sel;
    logic [WIDTH-1:0]   simple_res;

    assign in_ready  = ~flush & ((state_q == S_IDLE) |
                                 ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign is_clmul  = (op == OP_CLMUL) | (op == OP_CLMULH) | (op == OP_CLMULR);
    assign last      = (cnt_q == CW'(N - 1));
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;
    assign tag_out   = tag_q;

    assign base    = BW'(cnt_q) << SW;
    assign b_slice = b_q[base +: STEP];

    clmul_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .a       (a_q),
        .b_slice (b_slice),
        .base    (base),
        .part    (part)
    );

    // Simple-op datapath; w64 forms operate on a[31:0] and sign-extend
    logic                    wop;
    logic [BW-1:0]           shamt;
    logic [4:0]              sh5;
    logic [WIDTH-1:0]        sum, dif;
    logic signed [WIDTH-1:0] sra_f;
    logic [31:0]             a32, sll_w, srl_w;
    logic signed [31:0]      sra_w;

    always_comb begin
        wop   = (WIDTH == 64) && w64;
        shamt = b[BW-1:0];
        sh5   = b[4:0];
        a32   = a[31:0];
        sum   = a + b;
        dif   = a - b;
        sra_f = $signed(a) >>> shamt;
        sll_w = a32 << sh5;
        srl_w = a32 >> sh5;
        sra_w = $signed(a32) >>> sh5;
        simple_res = '0;
        unique case (op)
            OP_ADD:  simple_res = wop ? WIDTH'($signed(sum[31:0])) : sum;
            OP_SUB:  simple_res = wop ? WIDTH'($signed(dif[31:0])) : dif;
            OP_SLL:  simple_res = wop ? WIDTH'($signed(sll_w)) : a << shamt;
            OP_SRL:  simple_res = wop ? WIDTH'($signed(srl_w)) : a >> shamt;
            OP_SRA:  simple_res = wop ? WIDTH'(sra_w) : WIDTH'(sra_f);
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:  simple_res = a ^ b;
            OP_OR:   simple_res = a | b;
            OP_AND:  simple_res = a & b;
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        tag_d    = tag_q;
        result_d = result_q;
        sel      = clmul_sel((2*XMAX)'(acc_q ^ part), WIDTH, op_q);
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        tag_d = tag_in;
                        if (is_clmul) begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            a_d     = a;
                            b_d     = b;
                            op_d    = op;
                            state_d = S_BUSY;
                        end else begin
                            result_d = simple_res;
                            state_d  = S_DONE;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    acc_d = acc_q ^ part;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        result_d = sel[WIDTH-1:0];
                        state_d  = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: a 32-bit/STEP=8 instance for most
// scenarios and a 64-bit instance for the W-suffix ops.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    int          tests = 0;
    int          fails = 0;

    logic        flush, in_valid, in_ready, w64, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  tag_in, tag_out;

    logic        d_flush, d_in_valid, d_in_ready, d_w64;
    logic        d_out_valid, d_out_ready, d_busy;
    logic [3:0]  d_op;
    logic [63:0] d_a, d_b, d_result;
    logic [4:0]  d_tag_in, d_tag_out;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .STEP(8), .TAGW(5)) u32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .w64(w64),
        .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .tag_out(tag_out),
        .busy(busy)
    );

    alu_mc #(.WIDTH(64), .STEP(8), .TAGW(5)) u64 (
        .clk(clk), .reset_n(reset_n), .flush(d_flush),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .op(d_op),
        .w64(d_w64), .a(d_a), .b(d_b), .tag_in(d_tag_in),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .tag_out(d_tag_out), .busy(d_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tag_in = t;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b want 0 0",
                     out_valid, busy);
        end
        tests++;
        if (result !== 32'h0 || tag_out !== 5'h0) begin
            fails++;
            $display("FAIL reset_data: result=%h tag=%h want 0 0",
                     result, tag_out);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_simple();
        logic [3:0]  ops [6] = '{4'd0, 4'd5, 4'd6, 4'd4, 4'd7, 4'd14};
        logic [31:0] xa  [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                                 32'h80000000, 32'hF0F0F0F0, 32'h12345678};
        logic [31:0] xb  [6] = '{32'h1, 32'h0, 32'h0, 32'd31,
                                 32'hFF00FF00, 32'h1};
        logic [31:0] exp [6] = '{32'h80000000, 32'h1, 32'h0, 32'hFFFFFFFF,
                                 32'h0FF00FF0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xa[i], xb[i], 5'(i + 1));
            tests++;
            if (out_valid !== 1'b1 || result !== exp[i] ||
                tag_out !== 5'(i + 1)) begin
                fails++;
                $display("FAIL simple[%0d]: v=%b res=%h tag=%h want 1 %h %h",
                         i, out_valid, result, tag_out, exp[i], 5'(i + 1));
            end
        end
        step();
    endtask

    task automatic test_w64();
        logic [3:0]  ops [3] = '{4'd1, 4'd2, 4'd4};
        logic [63:0] xa  [3] = '{64'h1_0000_0000, 64'h1, 64'hFFFF_0000_8000_0000};
        logic [63:0] xb  [3] = '{64'h1, 64'd35, 64'd4};
        logic [63:0] exp [3] = '{64'hFFFFFFFF_FFFFFFFF, 64'h8,
                                 64'hFFFFFFFF_F8000000};
        d_w64 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in_valid = 1'b1;
            d_op = ops[i];
            d_a = xa[i];
            d_b = xb[i];
            d_tag_in = 5'(i + 10);
            step();
            d_in_valid = 1'b0;
            tests++;
            if (d_out_valid !== 1'b1 || d_result !== exp[i]) begin
                fails++;
                $display("FAIL w64[%0d]: v=%b res=%h want 1 %h",
                         i, d_out_valid, d_result, exp[i]);
            end
        end
        d_w64 = 1'b0;
        step();
    endtask

    task automatic test_clmul();
        logic [3:0]  ops [5] = '{4'd10, 4'd11, 4'd12, 4'd10, 4'd11};
        logic [31:0] xa  [5] = '{32'h3, 32'h80000000, 32'h80000000,
                                 32'h12345678, 32'h12345678};
        logic [31:0] xb  [5] = '{32'h3, 32'h80000000, 32'h80000000,
                                 32'h01000001, 32'h01000001};
        logic [31:0] exp [5] = '{32'h5, 32'h40000000, 32'h80000000,
                                 32'h6A345678, 32'h00123456};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], xa[i], xb[i], 5'(i + 20));
            lat = 0;
            bc = 0;
            while (out_valid !== 1'b1 && lat < 20) begin
                if (busy === 1'b1) bc++;
                step();
                lat++;
            end
            tests++;
            if (lat != 4 || bc != 4) begin
                fails++;
                $display("FAIL clmul_lat[%0d]: lat=%0d busy=%0d want 4 4",
                         i, lat, bc);
            end
            tests++;
            if (result !== exp[i] || tag_out !== 5'(i + 20)) begin
                fails++;
                $display("FAIL clmul_res[%0d]: res=%h tag=%h want %h %h",
                         i, result, tag_out, exp[i], 5'(i + 20));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2, 5'd3);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || result !== 32'd3 || tag_out !== 5'd3 ||
                in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: v=%b res=%h tag=%h rdy=%b want 1 3 3 0",
                         i, out_valid, result, tag_out, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 4'd7;
        a = 32'hF0;
        b = 32'h0F;
        tag_in = 5'd7;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 32'hFF || tag_out !== 5'd7) begin
            fails++;
            $display("FAIL b2b_res: v=%b res=%h tag=%h want 1 ff 7",
                     out_valid, result, tag_out);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_retire: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic seen;
        issue(4'd10, 32'h3, 32'h3, 5'd9);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step();
        end
        tests++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy: seen=%b busy=%b want 0 0", seen, busy);
        end
        flush = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        flush = 1'b0;
        #1;
        issue(4'd0, 32'd2, 32'd3, 5'd4);
        tests++;
        if (out_valid !== 1'b1 || result !== 32'd5 || tag_out !== 5'd4) begin
            fails++;
            $display("FAIL flush_add: v=%b res=%h tag=%h want 1 5 4",
                     out_valid, result, tag_out);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(4'd12, 32'h80000000, 32'h80000000, 5'd5);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 ||
            tag_out !== 5'h0) begin
            fails++;
            $display("FAIL rst_mid: v=%b res=%h busy=%b tag=%h want 0 0 0 0",
                     out_valid, result, busy, tag_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
        issue(4'd10, 32'h3, 32'h3, 5'd6);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests++;
        if (lat != 4 || result !== 32'h5 || tag_out !== 5'd6) begin
            fails++;
            $display("FAIL rst_clmul: lat=%0d res=%h tag=%h want 4 5 6",
                     lat, result, tag_out);
        end
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        op = '0;
        w64 = 1'b0;
        a = '0;
        b = '0;
        tag_in = '0;
        out_ready = 1'b1;
        d_flush = 1'b0;
        d_in_valid = 1'b0;
        d_op = '0;
        d_w64 = 1'b0;
        d_a = '0;
        d_b = '0;
        d_tag_in = '0;
        d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        test_reset();
        step();
        test_simple();
        test_w64();
        test_clmul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
